// File: rtl/pcap_replay_rd_sequencer_if.sv
// Read-request / read-return bundle between the replay read sequencer and the
// QDR user read port. The sequencer is the master: it drives the requests and
// observes the acceptance and the returned-burst pulses.
interface pcap_replay_rd_sequencer_if #(
  parameter int unsigned QDR_ADDR_WIDTH = 19
) ();

  logic                      rd_req_valid;
  logic [QDR_ADDR_WIDTH-1:0] rd_req_addr;
  logic                      rd_req_ready;
  logic                      rd_data_valid;

  modport master (
    output rd_req_valid,
    output rd_req_addr,
    input  rd_req_ready,
    input  rd_data_valid
  );

  modport slave (
    input  rd_req_valid,
    input  rd_req_addr,
    output rd_req_ready,
    output rd_data_valid
  );

endinterface

// File: rtl/pcap_replay_rd_sequencer.sv
// pcap replay read sequencer.
// Walks the packet image in the QDR store from address 0 up to an exclusive
// end address, once per pass, for replay_count passes (0 = run until start
// drops). The number of accepted-but-unreturned bursts is capped so that the
// returned data can never overrun the egress FIFO.
module pcap_replay_rd_sequencer #(
  parameter int unsigned QDR_ADDR_WIDTH     = 19,
  parameter int unsigned REPLAY_COUNT_WIDTH = 32,
  parameter int unsigned ADDR_STEP          = 1,
  parameter int unsigned MAX_OUTSTANDING    = 8
) (
  input  logic                                axi_aclk,
  input  logic                                axi_aresetn,
  input  logic                                sw_rst,
  input  logic                                start_replay,
  input  logic [QDR_ADDR_WIDTH-1:0]           mem_addr_high,
  input  logic [REPLAY_COUNT_WIDTH-1:0]       replay_count,
  pcap_replay_rd_sequencer_if.master          rd_if,
  output logic                                replay_busy,
  output logic                                replay_done,
  output logic [REPLAY_COUNT_WIDTH-1:0]       loop_count,
  output logic [$clog2(MAX_OUTSTANDING):0]    rd_outstanding,
  output logic                                rd_err
);

  localparam int unsigned AW = QDR_ADDR_WIDTH;
  localparam int unsigned RW = REPLAY_COUNT_WIDTH;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [AW:0]   STEP_EXT = (AW+1)'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            start_prev;
  logic            start_edge;
  logic            take_start;

  logic [AW-1:0]   end_addr;
  logic [RW-1:0]   pass_cnt;
  logic [AW-1:0]   addr;
  logic [AW:0]     addr_inc;
  logic            pass_end;
  logic            last_pass;

  logic            credit;
  logic            req_valid;
  logic            hs;
  logic            spurious;

  // Previous start level; deliberately not reset so that it always holds the
  // level sampled on the last clock, including during reset. A level that is
  // already high when reset releases therefore never looks like an edge.
  always_ff @(posedge axi_aclk) begin
    start_prev <= start_replay;
  end

  assign start_edge = start_replay && !start_prev;

  // Next address is formed one bit wider so the end-of-pass compare never
  // sees a wrapped value.
  assign addr_inc  = {1'b0, addr} + STEP_EXT;
  assign pass_end  = (addr_inc >= {1'b0, end_addr});
  assign last_pass = (pass_cnt != '0) && ((loop_count + RW'(1)) == pass_cnt);

  assign credit    = (rd_outstanding < MAX_OUT);
  assign spurious  = rd_if.rd_data_valid && (rd_outstanding == '0);

  assign rd_if.rd_req_valid = req_valid;
  assign rd_if.rd_req_addr  = addr;

  // FSM state register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state <= IDLE;
    end else if (sw_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state, request handshake and status outputs.
  always_comb begin
    state_nxt   = state;
    req_valid   = 1'b0;
    hs          = 1'b0;
    take_start  = 1'b0;
    replay_busy = (state != IDLE);
    replay_done = (state == DONE);

    unique case (state)
      IDLE: begin
        if (start_edge) begin
          take_start = 1'b1;
          state_nxt  = (mem_addr_high == '0) ? DONE : ISSUE;
        end
      end

      ISSUE: begin
        // sw_rst drops the request in the same cycle; the QDR side is being
        // reset alongside, so no handshake can complete under it.
        req_valid = credit && !sw_rst;
        hs        = req_valid && rd_if.rd_req_ready;
        if (hs && pass_end && last_pass) begin
          state_nxt = DRAIN;
        end else if (!start_replay && (!req_valid || hs)) begin
          // Abort only when no request is pending, so one is never withdrawn.
          state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        if (rd_outstanding == '0) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Replay configuration latch, address walk, pass counter, in-flight
  // counter and sticky return error.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      end_addr       <= '0;
      pass_cnt       <= '0;
      addr           <= '0;
      loop_count     <= '0;
      rd_outstanding <= '0;
      rd_err         <= 1'b0;
    end else if (sw_rst) begin
      end_addr       <= '0;
      pass_cnt       <= '0;
      addr           <= '0;
      loop_count     <= '0;
      rd_outstanding <= '0;
      rd_err         <= 1'b0;
    end else begin
      if (take_start) begin
        end_addr   <= mem_addr_high;
        pass_cnt   <= replay_count;
        addr       <= '0;
        loop_count <= '0;
      end else if (hs) begin
        if (pass_end) begin
          addr       <= '0;
          loop_count <= loop_count + RW'(1);
        end else begin
          addr <= addr_inc[AW-1:0];
        end
      end

      if (hs && !rd_if.rd_data_valid) begin
        rd_outstanding <= rd_outstanding + OW'(1);
      end else if (!hs && rd_if.rd_data_valid && (rd_outstanding != '0)) begin
        rd_outstanding <= rd_outstanding - OW'(1);
      end

      rd_err <= (take_start ? 1'b0 : rd_err) | spurious;
    end
  end

endmodule

// File: tb/tb_pcap_replay_rd_sequencer.sv
// Directed bench for the pcap replay read sequencer: a table of replay
// configurations walked in a loop, plus hand-written multi-cycle sequences.
module tb_pcap_replay_rd_sequencer;

  localparam int unsigned AW   = 19;
  localparam int unsigned RW   = 32;
  localparam int unsigned MAXO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sw_rst;
  logic          start;
  logic [AW-1:0] mem_addr_high;
  logic [RW-1:0] replay_count;
  logic          busy;
  logic          done;
  logic [RW-1:0] loop_count;
  logic [3:0]    outstanding;
  logic          err;

  pcap_replay_rd_sequencer_if #(.QDR_ADDR_WIDTH(AW)) rd_if ();

  pcap_replay_rd_sequencer #(
    .QDR_ADDR_WIDTH(AW),
    .REPLAY_COUNT_WIDTH(RW),
    .ADDR_STEP(1),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(rstn),
    .sw_rst(sw_rst),
    .start_replay(start),
    .mem_addr_high(mem_addr_high),
    .replay_count(replay_count),
    .rd_if(rd_if),
    .replay_busy(busy),
    .replay_done(done),
    .loop_count(loop_count),
    .rd_outstanding(outstanding),
    .rd_err(err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc, hs_count, done_count, ret_count, ret_at_done, addr_err;
  int unsigned ready_period;
  logic [AW-1:0] exp_addr, cur_end;
  logic [2:0]  ret_pipe;
  bit          auto_ret, manual_dv, ready_low;

  typedef struct {
    int unsigned end_a;
    int unsigned cnt;
    int unsigned ready_period;
    int unsigned exp_hs;
    int unsigned exp_loop;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: apply ready, record handshakes against the address model,
  // advance the 3-cycle read-return pipe.
  task automatic step();
    bit h;
    rd_if.rd_req_ready = ready_low ? 1'b0 : ((cyc % ready_period) == 0);
    #1;
    h = rd_if.rd_req_valid && rd_if.rd_req_ready;
    if (h) begin
      hs_count++;
      if (rd_if.rd_req_addr !== exp_addr) addr_err++;
      exp_addr = ((exp_addr + 1) >= cur_end) ? '0 : exp_addr + 1'b1;
    end
    if (done) begin
      done_count++;
      ret_at_done = ret_count;
    end
    if (rd_if.rd_data_valid) ret_count++;
    @(posedge clk);
    #1;
    cyc++;
    ret_pipe = {ret_pipe[1:0], h};
    rd_if.rd_data_valid = auto_ret ? ret_pipe[2] : manual_dv;
    manual_dv = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic clear_counts();
    hs_count = 0; done_count = 0; ret_count = 0; ret_at_done = 0;
    addr_err = 0; exp_addr = '0; ret_pipe = '0;
  endtask

  task automatic arm(input int unsigned end_a, input int unsigned cnt);
    mem_addr_high = AW'(end_a);
    cur_end       = AW'(end_a);
    replay_count  = RW'(cnt);
    clear_counts();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{end_a: 4, cnt: 2, ready_period: 1, exp_hs: 8,  exp_loop: 2};
    vecs[1] = '{end_a: 1, cnt: 3, ready_period: 1, exp_hs: 3,  exp_loop: 3};
    vecs[2] = '{end_a: 3, cnt: 1, ready_period: 2, exp_hs: 3,  exp_loop: 1};
    vecs[3] = '{end_a: 5, cnt: 2, ready_period: 3, exp_hs: 10, exp_loop: 2};
    vecs[4] = '{end_a: 2, cnt: 4, ready_period: 1, exp_hs: 8,  exp_loop: 4};
    vecs[5] = '{end_a: 7, cnt: 1, ready_period: 1, exp_hs: 7,  exp_loop: 1};

    cyc = 0; ready_period = 1; ready_low = 1'b0; auto_ret = 1'b0; manual_dv = 1'b0;
    clear_counts();
    rstn = 1'b0; sw_rst = 1'b0; start = 1'b1;
    mem_addr_high = AW'(4); replay_count = '0; cur_end = AW'(4);
    rd_if.rd_data_valid = 1'b0; rd_if.rd_req_ready = 1'b1;

    // Reset state, with start already high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rd_if.rd_req_valid, 0);
    check("rst_addr", rd_if.rd_req_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_loop", loop_count, 0);
    check("rst_outst", outstanding, 0);
    check("rst_err", err, 0);
    rstn = 1'b1;
    repeat (5) step();
    check("hi_at_release_busy", busy, 0);
    check("hi_at_release_hs", hs_count, 0);

    // Return pulse with nothing in flight.
    start = 1'b0;
    manual_dv = 1'b1;
    step();
    step();
    check("idle_ret_err", err, 1);
    check("idle_ret_outst", outstanding, 0);

    // end == 0: straight to DONE.
    arm(0, 1);
    check("end0_done", done, 1);
    check("end0_busy", busy, 1);
    check("end0_valid", rd_if.rd_req_valid, 0);
    check("end0_err_cleared", err, 0);
    step();
    check("end0_done_off", done, 0);
    check("end0_busy_off", busy, 0);
    check("end0_hs", hs_count, 0);

    // Table-driven replays with 3-cycle read return.
    auto_ret = 1'b1;
    foreach (vecs[i]) begin
      ready_period = vecs[i].ready_period;
      arm(vecs[i].end_a, vecs[i].cnt);
      check($sformatf("v%0d_first_valid", i), rd_if.rd_req_valid, 1);
      check($sformatf("v%0d_first_addr", i), rd_if.rd_req_addr, 0);
      wait_idle($sformatf("v%0d_timeout", i));
      start = 1'b0;
      step();
      check($sformatf("v%0d_hs", i), hs_count, vecs[i].exp_hs);
      check($sformatf("v%0d_addr_seq", i), addr_err, 0);
      check($sformatf("v%0d_loop", i), loop_count, vecs[i].exp_loop);
      check($sformatf("v%0d_done_cnt", i), done_count, 1);
      check($sformatf("v%0d_ret_at_done", i), ret_at_done, vecs[i].exp_hs);
      check($sformatf("v%0d_outst", i), outstanding, 0);
    end
    ready_period = 1;

    // Credit cap: no returns, exactly MAXO handshakes.
    auto_ret = 1'b0;
    arm(100, 0);
    repeat (20) step();
    check("cap_hs", hs_count, MAXO);
    check("cap_outst", outstanding, MAXO);
    check("cap_valid", rd_if.rd_req_valid, 0);
    manual_dv = 1'b1;
    repeat (5) step();
    check("cap_hs_after_ret", hs_count, MAXO + 1);
    check("cap_outst_after_ret", outstanding, MAXO);
    start = 1'b0;
    step();
    check("cap_drain_busy", busy, 1);
    repeat (MAXO) begin
      manual_dv = 1'b1;
      step();
    end
    wait_idle("cap_timeout");
    check("cap_err", err, 0);
    check("cap_loop", loop_count, 0);
    check("cap_addr_seq", addr_err, 0);

    // Infinite replay, end=2, start held 100 cycles.
    auto_ret = 1'b1;
    arm(2, 0);
    repeat (100) step();
    start = 1'b0;
    step();
    wait_idle("inf_timeout");
    check("inf_hs", hs_count, 101);
    check("inf_addr_seq", addr_err, 0);
    check("inf_loop", loop_count, 50);
    check("inf_done_cnt", done_count, 1);

    // Abort while a request is stalled on ready.
    arm(10, 0);
    repeat (3) step();
    ready_low = 1'b1;
    repeat (2) step();
    start = 1'b0;
    repeat (3) step();
    check("stall_valid", rd_if.rd_req_valid, 1);
    check("stall_addr", rd_if.rd_req_addr, 3);
    check("stall_busy", busy, 1);
    ready_low = 1'b0;
    step();
    check("stall_abort_valid", rd_if.rd_req_valid, 0);
    check("stall_hs", hs_count, 4);
    wait_idle("stall_timeout");
    check("stall_addr_seq", addr_err, 0);
    check("stall_loop", loop_count, 0);

    // Soft reset mid-ISSUE with 5 in flight.
    auto_ret = 1'b0;
    arm(10, 0);
    repeat (5) step();
    check("swr_pre_outst", outstanding, 5);
    sw_rst = 1'b1;
    step();
    check("swr_valid", rd_if.rd_req_valid, 0);
    check("swr_addr", rd_if.rd_req_addr, 0);
    check("swr_busy", busy, 0);
    check("swr_done", done, 0);
    check("swr_loop", loop_count, 0);
    check("swr_outst", outstanding, 0);
    check("swr_err", err, 0);
    sw_rst = 1'b0;
    repeat (3) step();
    check("swr_level_no_start", busy, 0);
    arm(10, 0);
    check("swr_restart_valid", rd_if.rd_req_valid, 1);
    check("swr_restart_addr", rd_if.rd_req_addr, 0);
    repeat (2) step();
    auto_ret = 1'b1;
    start = 1'b0;
    wait_idle("swr_timeout");
    check("swr_restart_seq", addr_err, 0);
    check("swr_restart_err", err, 0);
    check("swr_restart_outst", outstanding, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
